// File: rtl/quant_out_stage.sv
// rtl/quant_out_stage.sv - round/saturate MAC results into a small output FIFO
// Optional ReLU clamp of negative results when QOUT_RELU_EN is defined.
module quant_out_stage #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] acc_in,
  input  logic        acc_last,
  input  logic [3:0]  shift,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        fifo_full,
  output logic [7:0]  ovf_cnt,
  output logic        drop_err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic              s1_vld_q, s1_vld_d;
  logic [31:0]       s1_acc_q, s1_acc_d;
  logic [3:0]        s1_shift_q, s1_shift_d;
  logic [15:0]       mem_q [DEPTH];
  logic [15:0]       mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [7:0]        ovf_q, ovf_d;
  logic              drop_q, drop_d;

  logic signed [32:0] acc_ext, rnd, sum, shifted;
  logic [15:0]        res;
  logic               clamp, push, pop, full, wr_en;

  always_comb begin
    s1_vld_d   = acc_last;
    s1_acc_d   = acc_last ? acc_in : s1_acc_q;
    s1_shift_d = acc_last ? shift : s1_shift_q;

    // 33-bit sum cannot overflow: |acc| < 2^31 and the rounding term is <= 2^14
    acc_ext = {s1_acc_q[31], s1_acc_q};
    rnd     = (s1_shift_q == 4'd0) ? '0 : (33'sd1 <<< (s1_shift_q - 4'd1));
    sum     = acc_ext + rnd;
    shifted = sum >>> s1_shift_q;

    clamp = 1'b0;
    if (shifted > 33'sd32767) begin
      res   = 16'h7FFF;
      clamp = 1'b1;
    end else if (shifted < -33'sd32768) begin
      res   = 16'h8000;
      clamp = 1'b1;
    end else begin
      res = shifted[15:0];
    end
`ifdef QOUT_RELU_EN
    if (res[15]) res = 16'h0000;
`else
`endif

    full  = (cnt_q == FULL_CNT);
    pop   = (cnt_q != '0) && out_ready;
    push  = s1_vld_q;
    wr_en = push && (!full || pop);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;

    if (wr_en) begin
      mem_d[wr_ptr_q] = res;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (push && clamp && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;
    if (push && full && !pop) drop_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q   <= 1'b0;
      s1_acc_q   <= '0;
      s1_shift_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= '0;
      drop_q     <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_acc_q   <= s1_acc_d;
      s1_shift_q <= s1_shift_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  assign out_valid = (cnt_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : 16'h0000;
  assign fifo_full = full;
  assign ovf_cnt   = ovf_q;
  assign drop_err  = drop_q;
endmodule

// File: tb/tb_quant_out_stage.sv
// tb/tb_quant_out_stage.sv - scoreboard bench for quant_out_stage
module tb_quant_out_stage;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] acc_in = '0;
  logic        acc_last = 1'b0;
  logic [3:0]  shift = '0;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_valid;
  logic        fifo_full;
  logic [7:0]  ovf_cnt;
  logic        drop_err;

  quant_out_stage #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .acc_in(acc_in), .acc_last(acc_last),
    .shift(shift), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_full(fifo_full), .ovf_cnt(ovf_cnt),
    .drop_err(drop_err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // expected results in issue order, written only by the stimulus
  logic [15:0] exp_v [0:1023];
  bit          exp_c [0:1023];
  int          n_iss = 0;

  // monitor-side model state
  int fq[$];
  bit s1_v = 1'b0;
  int s1_idx = 0;
  int n_taken = 0;
  int m_ovf = 0;
  bit m_drop = 1'b0;

  function automatic void ref_q(input logic [31:0] a, input int sh,
                                output logic [15:0] v, output bit c);
    longint x;
    x = longint'($signed(a));
    if (sh > 0) x = (x + (longint'(1) << (sh - 1))) >>> sh;
    c = 1'b0;
    if (x > 32767) begin x = 32767; c = 1'b1; end
    if (x < -32768) begin x = -32768; c = 1'b1; end
`ifdef QOUT_RELU_EN
    if (x < 0) x = 0;
`endif
    v = x[15:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    bit pop, full;
    if (!reset_n) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_fifo_full", 32'(fifo_full), 32'd0);
      chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
      chk("rst_drop_err", 32'(drop_err), 32'd0);
      fq.delete();
      s1_v = 1'b0;
      m_ovf = 0;
      m_drop = 1'b0;
      n_taken = n_iss;
    end else begin
      chk("out_valid", 32'(out_valid), 32'(fq.size() != 0));
      if (fq.size() != 0) chk("out_data", 32'(out_data), 32'(exp_v[fq[0]]));
      chk("fifo_full", 32'(fifo_full), 32'(fq.size() == DEPTH));
      chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
      chk("drop_err", 32'(drop_err), 32'(m_drop));
      // predict the effect of the coming rising edge
      pop  = (fq.size() != 0) && out_ready;
      full = (fq.size() == DEPTH);
      if (s1_v) begin
        if (exp_c[s1_idx] && m_ovf < 255) m_ovf++;
        if (full && !pop) m_drop = 1'b1;
      end
      if (pop) void'(fq.pop_front());
      if (s1_v && !(full && !pop)) fq.push_back(s1_idx);
      s1_v = acc_last;
      if (acc_last) begin
        s1_idx = n_taken;
        n_taken++;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input int sh);
    logic [15:0] v;
    bit c;
    @(posedge clock);
    #1;
    ref_q(a, sh, v, c);
    exp_v[n_iss] = v;
    exp_c[n_iss] = c;
    n_iss++;
    acc_in = a;
    shift = 4'(sh);
    acc_last = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      acc_last = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] r;
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;

    issue(32'h0001_2345, 4);
    idle(4);
    issue(32'h0010_0000, 0);
    issue(32'hFFF0_0000, 0);
    issue(32'h0000_0003, 1);
    issue(32'hFFFF_FFFD, 1);
    issue(32'hFFFF_FF9C, 0);
    idle(5);

    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) issue(32'(i), 0);
    idle(4);
    out_ready = 1'b1;
    idle(6);

    out_ready = 1'b0;
    issue(32'h7FFF_FFFF, 0);
    issue(32'h0000_1000, 2);
    issue(32'h8000_0000, 15);
    idle(3);
    @(posedge clock);
    #2 reset_n = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b1;
    out_ready = 1'b1;
    idle(2);

    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 7) begin
        r = $urandom;
        if ($urandom_range(0, 1) == 1) r = {{12{r[19]}}, r[19:0]};
        issue(r, int'($urandom_range(0, 15)));
      end else begin
        idle(1);
      end
    end
    out_ready = 1'b1;
    idle(DEPTH + 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
